// File: rtl/vbuf_pkg.sv
// vbuf_pkg: shared constants, types and helpers for the vertical buffer bank.
//   VBUF_DATA_W / VBUF_NUM_CH / VBUF_DEPTH : default geometry of the bank
//   cnt_w(depth)                           : width needed to hold 0..depth
//   vbuf_mode_e                            : read mode selected by `lockstep`
package vbuf_pkg;

  localparam int unsigned VBUF_DATA_W = 8;
  localparam int unsigned VBUF_NUM_CH = 16;
  localparam int unsigned VBUF_DEPTH  = 8;

  typedef enum logic [0:0] {
    VBUF_INDEP    = 1'b0,
    VBUF_LOCKSTEP = 1'b1
  } vbuf_mode_e;

  // Occupancy runs 0..depth inclusive, hence depth+1 states.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vbuf_chan.sv
// vbuf_chan: one first-word-fall-through FIFO channel of the buffer bank.
// It carries out the strobes it is given; all handshake decisions are made
// by the caller, which must never push when full or pop when empty.
//   clk, rst  : clock, asynchronous active-low reset (pointers and level)
//   push      : write wdata at the tail this cycle
//   pop       : drop the head element this cycle
//   flush     : clear pointers and level on the next edge (beats push/pop)
//   wdata     : element to write
//   rdata     : current head element (raw storage, not qualified)
//   level     : current occupancy, 0..DEPTH
module vbuf_chan
  import vbuf_pkg::*;
#(
  parameter int unsigned DATA_W = VBUF_DATA_W,
  parameter int unsigned DEPTH  = VBUF_DEPTH,
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  level
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  // Storage is deliberately left out of reset and flush; only pointers and
  // level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        level_d = level_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        level_d = level_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/vbuf_bank.sv
// vbuf_bank: NUM_CH independent column FIFOs between data_setup_v and the PE
// columns, with per-channel occupancy, bank-wide synchronous flush and an
// optional lockstep read mode in which every column pops together.
//   clk, rst         : clock, asynchronous active-low reset
//   flush            : synchronous clear of every channel (beats push/pop)
//   lockstep         : 0 independent reads, 1 lockstep reads (change only
//                      while all_empty)
//   in_col           : per-channel write data
//   fifo_WVALID_col  : per-channel write request
//   fifo_WREADY_col  : per-channel write accept
//   fifo_RVALID_col  : per-channel pop request (only bit 0 used in lockstep)
//   fifo_RREADY_col  : per-channel head valid on out_col
//   out_col          : head element, zero while its RREADY is low
//   level_col        : per-channel occupancy
//   almost_full      : some channel at or above AF_THRESH
//   all_empty        : every channel empty
module vbuf_bank
  import vbuf_pkg::*;
#(
  parameter int unsigned NUM_CH    = VBUF_NUM_CH,
  parameter int unsigned DATA_W    = VBUF_DATA_W,
  parameter int unsigned DEPTH     = VBUF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  localparam int unsigned CNT_W    = cnt_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           lockstep,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  in_col,
  input  logic [NUM_CH-1:0]              fifo_WVALID_col,
  output logic [NUM_CH-1:0]              fifo_WREADY_col,
  input  logic [NUM_CH-1:0]              fifo_RVALID_col,
  output logic [NUM_CH-1:0]              fifo_RREADY_col,
  output logic [NUM_CH-1:0][DATA_W-1:0]  out_col,
  output logic [NUM_CH-1:0][CNT_W-1:0]   level_col,
  output logic                           almost_full,
  output logic                           all_empty
);

  logic [NUM_CH-1:0][DATA_W-1:0] head;
  logic [NUM_CH-1:0]             non_empty;
  logic [NUM_CH-1:0]             af_hit;
  logic [NUM_CH-1:0]             push;
  logic [NUM_CH-1:0]             pop;
  logic                          all_non_empty;
  logic                          lock_ready;
  logic                          lock_pop;
  vbuf_mode_e                    mode;

  assign mode = vbuf_mode_e'(lockstep);

  // Status flags come purely from registered levels.
  always_comb begin
    non_empty = '0;
    af_hit    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      non_empty[i] = (level_col[i] != '0);
      af_hit[i]    = (level_col[i] >= CNT_W'(AF_THRESH));
    end
  end

  assign all_non_empty = &non_empty;
  assign all_empty     = ~|non_empty;
  assign almost_full   = |af_hit;

  // In lockstep a wavefront is only released once every column holds data,
  // and column 0's request pops them all so no column can run ahead.
  assign lock_ready = all_non_empty && !flush;
  assign lock_pop   = fifo_RVALID_col[0] && lock_ready;

  always_comb begin
    fifo_WREADY_col = '0;
    fifo_RREADY_col = '0;
    push            = '0;
    pop             = '0;
    out_col         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Full is judged on the current level only, so a same-cycle pop
      // never frees room for a write.
      fifo_WREADY_col[i] = (level_col[i] != CNT_W'(DEPTH)) && !flush;
      push[i]            = fifo_WVALID_col[i] && fifo_WREADY_col[i];
      unique case (mode)
        VBUF_LOCKSTEP: begin
          fifo_RREADY_col[i] = lock_ready;
          pop[i]             = lock_pop;
        end
        default: begin
          fifo_RREADY_col[i] = non_empty[i] && !flush;
          pop[i]             = fifo_RVALID_col[i] && non_empty[i] && !flush;
        end
      endcase
      out_col[i] = fifo_RREADY_col[i] ? head[i] : '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    vbuf_chan #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .flush (flush),
      .wdata (in_col[g]),
      .rdata (head[g]),
      .level (level_col[g])
    );
  end

endmodule

// File: tb/tb_vbuf_bank.sv
// tb_vbuf_bank: table-driven, hand-sequenced and randomised checks of
// vbuf_bank against a queue-based reference model.
module tb_vbuf_bank;
  import vbuf_pkg::*;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AF_TH  = DEPTH - 2;
  localparam int unsigned CNT_W  = cnt_w(DEPTH);

  logic                          clk;
  logic                          rst;
  logic                          flush;
  logic                          lockstep;
  logic [NUM_CH-1:0][DATA_W-1:0] in_col;
  logic [NUM_CH-1:0]             wvalid;
  logic [NUM_CH-1:0]             wready;
  logic [NUM_CH-1:0]             rvalid;
  logic [NUM_CH-1:0]             rready;
  logic [NUM_CH-1:0][DATA_W-1:0] out_col;
  logic [NUM_CH-1:0][CNT_W-1:0]  level_col;
  logic                          almost_full;
  logic                          all_empty;

  int checks;
  int errors;

  logic [DATA_W-1:0] mq [NUM_CH][$];

  typedef struct {
    logic              wv;
    logic              rv;
    logic [DATA_W-1:0] din;
    logic [CNT_W-1:0]  exp_level;
    logic              exp_wready;
    logic              exp_rready;
    logic [DATA_W-1:0] exp_out;
    logic              exp_af;
  } vec_t;

  vec_t vt [17];

  vbuf_bank #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .lockstep        (lockstep),
    .in_col          (in_col),
    .fifo_WVALID_col (wvalid),
    .fifo_WREADY_col (wready),
    .fifo_RVALID_col (rvalid),
    .fifo_RREADY_col (rready),
    .out_col         (out_col),
    .level_col       (level_col),
    .almost_full     (almost_full),
    .all_empty       (all_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) mq[i].delete();
  endtask

  // Advance the model by one clock from the current inputs, then the DUT.
  task automatic tick();
    bit all_ne;
    bit do_wr [NUM_CH];
    bit do_rd [NUM_CH];
    all_ne = 1'b1;
    for (int i = 0; i < NUM_CH; i++) if (mq[i].size() == 0) all_ne = 1'b0;
    if (flush) begin
      model_clear();
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        do_wr[i] = wvalid[i] && (mq[i].size() != DEPTH);
        if (lockstep) do_rd[i] = rvalid[0] && all_ne;
        else          do_rd[i] = rvalid[i] && (mq[i].size() != 0);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (do_rd[i]) void'(mq[i].pop_front());
        if (do_wr[i]) mq[i].push_back(in_col[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string nm);
    logic [NUM_CH-1:0]             e_wr;
    logic [NUM_CH-1:0]             e_rr;
    logic [NUM_CH-1:0][DATA_W-1:0] e_out;
    logic [NUM_CH-1:0][CNT_W-1:0]  e_lvl;
    bit all_ne;
    bit any_af;
    bit none;
    all_ne = 1'b1;
    any_af = 1'b0;
    none   = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mq[i].size() == 0) all_ne = 1'b0;
      else none = 1'b0;
      if (mq[i].size() >= AF_TH) any_af = 1'b1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      e_wr[i]  = (mq[i].size() != DEPTH) && !flush;
      e_rr[i]  = (lockstep ? all_ne : (mq[i].size() != 0)) && !flush;
      e_out[i] = e_rr[i] ? mq[i][0] : '0;
      e_lvl[i] = CNT_W'(mq[i].size());
    end
    chk({nm, ".wready"}, wready, e_wr);
    chk({nm, ".rready"}, rready, e_rr);
    chk({nm, ".out_col"}, out_col, e_out);
    chk({nm, ".level"}, level_col, e_lvl);
    chk({nm, ".almost_full"}, almost_full, any_af);
    chk({nm, ".all_empty"}, all_empty, none);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".wready"}, wready, {NUM_CH{1'b1}});
    chk({nm, ".rready"}, rready, '0);
    chk({nm, ".out_col"}, out_col, '0);
    chk({nm, ".level"}, level_col, '0);
    chk({nm, ".almost_full"}, almost_full, 1'b0);
    chk({nm, ".all_empty"}, all_empty, 1'b1);
  endtask

  task automatic idle();
    wvalid = '0;
    rvalid = '0;
    flush  = 1'b0;
  endtask

  task automatic rand_phase(input bit ls, input int n);
    flush = 1'b1;
    tick();
    idle();
    lockstep = ls;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NUM_CH; i++) in_col[i] = DATA_W'($urandom);
      wvalid = ls ? NUM_CH'($urandom | $urandom) : NUM_CH'($urandom);
      rvalid = NUM_CH'($urandom);
      flush  = ($urandom_range(0, 31) == 0);
      #1;
      check_model(ls ? "rand_lock" : "rand_indep");
      tick();
    end
    idle();
  endtask

  initial begin
    logic [DATA_W-1:0] eq [$];
    logic [DATA_W-1:0] hv;
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    lockstep = 1'b0;
    in_col   = '0;
    idle();

    // Fill/drain table for channel 3: eight pushes, a refused ninth, eight pops.
    for (int k = 0; k < 8; k++) begin
      vt[k].wv = 1'b1;  vt[k].rv = 1'b0;  vt[k].din = DATA_W'(8'h10 + k);
      vt[k].exp_level  = CNT_W'(k + 1);
      vt[k].exp_wready = (k + 1 != 8);
      vt[k].exp_rready = 1'b1;
      vt[k].exp_out    = 8'h10;
      vt[k].exp_af     = (k + 1 >= 6);
    end
    vt[8].wv = 1'b1;  vt[8].rv = 1'b0;  vt[8].din = 8'hEE;
    vt[8].exp_level = 4'd8;  vt[8].exp_wready = 1'b0;  vt[8].exp_rready = 1'b1;
    vt[8].exp_out = 8'h10;  vt[8].exp_af = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vt[9 + k].wv = 1'b0;  vt[9 + k].rv = 1'b1;  vt[9 + k].din = 8'h00;
      vt[9 + k].exp_level  = CNT_W'(7 - k);
      vt[9 + k].exp_wready = 1'b1;
      vt[9 + k].exp_rready = (k < 7);
      vt[9 + k].exp_out    = (k < 7) ? DATA_W'(8'h11 + k) : 8'h00;
      vt[9 + k].exp_af     = (7 - k >= 6);
    end

    // Reset held, then released away from a clock edge.
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_held");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("reset_release");

    for (int k = 0; k < 17; k++) begin
      wvalid[3] = vt[k].wv;
      rvalid[3] = vt[k].rv;
      in_col[3] = vt[k].din;
      tick();
      idle();
      #1;
      chk($sformatf("fill_drain[%0d].level", k), level_col[3], vt[k].exp_level);
      chk($sformatf("fill_drain[%0d].wready", k), wready[3], vt[k].exp_wready);
      chk($sformatf("fill_drain[%0d].rready", k), rready[3], vt[k].exp_rready);
      chk($sformatf("fill_drain[%0d].out", k), out_col[3], vt[k].exp_out);
      chk($sformatf("fill_drain[%0d].af", k), almost_full, vt[k].exp_af);
    end

    // Simultaneous push and pop on channel 5 at level 4.
    for (int k = 0; k < 4; k++) begin
      wvalid[5] = 1'b1;
      in_col[5] = DATA_W'(8'h50 + k);
      eq.push_back(DATA_W'(8'h50 + k));
      tick();
    end
    idle();
    #1;
    chk("pushpop.level_start", level_col[5], 4'd4);
    for (int k = 0; k < 20; k++) begin
      wvalid[5] = 1'b1;
      rvalid[5] = 1'b1;
      in_col[5] = DATA_W'(8'h60 + k);
      #1;
      hv = eq.pop_front();
      chk($sformatf("pushpop[%0d].out", k), out_col[5], hv);
      eq.push_back(DATA_W'(8'h60 + k));
      tick();
      chk($sformatf("pushpop[%0d].level", k), level_col[5], 4'd4);
    end
    idle();

    // Flush mid-stream with every request high.
    flush = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NUM_CH; i++) in_col[i] = DATA_W'(i * 16 + k);
      wvalid = '1;
      tick();
    end
    idle();
    #1;
    chk("flush.pre_level", level_col, {NUM_CH{4'd3}});
    flush  = 1'b1;
    wvalid = '1;
    rvalid = '1;
    #1;
    chk("flush.wready", wready, '0);
    chk("flush.rready", rready, '0);
    chk("flush.out_col", out_col, '0);
    tick();
    idle();
    #1;
    chk("flush.level", level_col, '0);
    chk("flush.all_empty", all_empty, 1'b1);

    // Lockstep gating.
    lockstep = 1'b1;
    for (int i = 0; i < NUM_CH; i++) in_col[i] = DATA_W'(8'h30 + i);
    wvalid = {1'b0, {(NUM_CH - 1){1'b1}}};
    tick();
    idle();
    #1;
    chk("lock.partial_rready", rready, '0);
    chk("lock.partial_out", out_col, '0);
    in_col[NUM_CH-1] = 8'hAA;
    wvalid[NUM_CH-1] = 1'b1;
    tick();
    idle();
    #1;
    chk("lock.full_rready", rready, {NUM_CH{1'b1}});
    chk("lock.out15", out_col[NUM_CH-1], 8'hAA);
    chk("lock.out0", out_col[0], 8'h30);
    rvalid = {{(NUM_CH - 1){1'b1}}, 1'b0};
    tick();
    idle();
    #1;
    chk("lock.upper_rvalid_ignored", level_col, {NUM_CH{4'd1}});
    rvalid[0] = 1'b1;
    tick();
    idle();
    #1;
    chk("lock.pop_level", level_col, '0);
    chk("lock.pop_all_empty", all_empty, 1'b1);
    check_model("lock.model");

    // Randomised traffic against the queue model, both modes.
    rand_phase(1'b0, 600);
    rand_phase(1'b1, 600);
    rand_phase(1'b0, 300);

    // Asynchronous reset dropped between edges while channels hold data.
    lockstep = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NUM_CH; i++) in_col[i] = DATA_W'($urandom);
      wvalid = '1;
      tick();
    end
    idle();
    #1;
    check_model("pre_async");
    #1;
    rst = 1'b0;
    #1;
    chk_reset("async_reset");
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_model("post_async");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
